// File: rtl/crc8_frame_arb.sv
// crc8_frame_arb: frame-level round-robin arbiter feeding one shared crc8_d8 engine
module crc8_frame_arb #(
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = 12,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_vld,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_rdy,
    output logic                 crc_din_vld,
    output logic [7:0]           crc_din,
    output logic                 crc_done,
    input  logic [7:0]           crc_dout,
    output logic                 res_vld,
    output logic [7:0]           res_crc,
    output logic [ID_W-1:0]      res_id,
    output logic [LEN_W-1:0]     res_len,
    output logic                 busy
);
    typedef enum logic [1:0] {INIT, IDLE, XFER, RSLT} state_t;
    state_t           state;
    logic [1:0]       rst_sync;
    logic             rst_int;
    logic [ID_W-1:0]  gnt;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  nxt;
    logic [ID_W-1:0]  cand;
    logic             accept;
    logic [LEN_W-1:0] len;

    // Reset asserts asynchronously and releases two edges later, in step with clk
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= '0;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int = rst_sync[1];

    // Round-robin pick: scanning downward leaves the first set bit after rr_ptr in nxt
    always_comb begin
        nxt  = '0;
        cand = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (req_vld[cand]) nxt = cand;
        end
    end

    assign accept      = (state == XFER) && req_vld[gnt];
    assign req_rdy     = accept ? (NUM_REQ'(1) << gnt) : '0;
    assign crc_din_vld = accept;
    assign crc_din     = (state == XFER) ? req_data[{gnt, 3'b000} +: 8] : 8'h00;
    assign crc_done    = rst_int && (state == INIT || state == RSLT);
    assign busy        = rst_int && (state != IDLE);

    // Frame sequencer: grant, count bytes, then publish the result and clear the engine
    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
            state   <= INIT;
            rr_ptr  <= ID_W'(NUM_REQ - 1);
            gnt     <= '0;
            len     <= '0;
            res_vld <= 1'b0;
            res_crc <= '0;
            res_id  <= '0;
            res_len <= '0;
        end else begin
            res_vld <= 1'b0;
            case (state)
                INIT: state <= IDLE;
                IDLE: if (|req_vld) begin
                    gnt   <= nxt;
                    state <= XFER;
                end
                XFER: if (accept) begin
                    len <= (len == '1) ? len : len + 1'b1;
                    if (req_last[gnt]) state <= RSLT;
                end
                RSLT: begin
                    res_crc <= crc_dout;
                    res_id  <= gnt;
                    res_len <= len;
                    res_vld <= 1'b1;
                    rr_ptr  <= gnt;
                    len     <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_crc8_frame_arb.sv
// tb_crc8_frame_arb: directed checks of the frame arbiter against a behavioural crc8_d8 engine
module tb_crc8_frame_arb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  vld_a = '0, last_a = '0, rdy_a;
    logic [31:0] data_a = '0;
    logic        dvld_a, done_a, rvld_a, busy_a;
    logic [7:0]  din_a, eng_a = 8'h00, rcrc_a;
    logic [1:0]  rid_a;
    logic [11:0] rlen_a;
    logic [3:0]  vld_b = '0, last_b = '0, rdy_b;
    logic [31:0] data_b = '0;
    logic        dvld_b, done_b, rvld_b, busy_b;
    logic [7:0]  din_b, eng_b = 8'h00, rcrc_b;
    logic [1:0]  rid_b;
    logic [3:0]  rlen_b;
    int checks = 0, passes = 0;
    int done_cnt = 0, overlap_cnt = 0, res_twice = 0;
    logic        rvld_prev = 1'b0;
    logic [1:0]  q_id[$];
    logic [7:0]  q_crc[$];
    logic [11:0] q_len[$];

    always #5 clk = ~clk;

    crc8_frame_arb #(.NUM_REQ(4), .LEN_W(12)) dut_a (
        .clk(clk), .reset_n(rst_n), .req_vld(vld_a), .req_data(data_a), .req_last(last_a),
        .req_rdy(rdy_a), .crc_din_vld(dvld_a), .crc_din(din_a), .crc_done(done_a),
        .crc_dout(eng_a), .res_vld(rvld_a), .res_crc(rcrc_a), .res_id(rid_a),
        .res_len(rlen_a), .busy(busy_a));

    crc8_frame_arb #(.NUM_REQ(4), .LEN_W(4)) dut_b (
        .clk(clk), .reset_n(rst_n), .req_vld(vld_b), .req_data(data_b), .req_last(last_b),
        .req_rdy(rdy_b), .crc_din_vld(dvld_b), .crc_din(din_b), .crc_done(done_b),
        .crc_dout(eng_b), .res_vld(rvld_b), .res_crc(rcrc_b), .res_id(rid_b),
        .res_len(rlen_b), .busy(busy_b));

    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] x = c ^ d;
        for (int k = 0; k < 8; k++) x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
        return x;
    endfunction

    // Shared crc8_d8 engines: no reset of their own, cleared only by crc_done
    always @(posedge clk) begin
        if (done_a) eng_a <= 8'h00;
        else if (dvld_a) eng_a <= crc_step(eng_a, din_a);
        if (done_b) eng_b <= 8'h00;
        else if (dvld_b) eng_b <= crc_step(eng_b, din_b);
    end

    // Result log and protocol watchers for dut_a
    always @(posedge clk) begin
        if (done_a) done_cnt++;
        if (done_a && dvld_a) overlap_cnt++;
        if (rvld_a && rvld_prev) res_twice++;
        rvld_prev <= rvld_a;
        if (rvld_a) begin
            q_id.push_back(rid_a);
            q_crc.push_back(rcrc_a);
            q_len.push_back(rlen_a);
        end
    end

    task automatic send_byte(input bit sel_b, input int lane, input logic [7:0] d,
                             input bit last, output bit ok);
        logic [3:0] r;
        ok = 1'b0;
        if (sel_b) begin
            data_b[lane*8 +: 8] = d; last_b[lane] = last; vld_b[lane] = 1'b1;
        end else begin
            data_a[lane*8 +: 8] = d; last_a[lane] = last; vld_a[lane] = 1'b1;
        end
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            r = sel_b ? rdy_b : rdy_a;
            if (r[lane]) begin
                @(posedge clk); #1;
                ok = 1'b1;
            end
        end
        if (sel_b) vld_b[lane] = 1'b0;
        else       vld_a[lane] = 1'b0;
    endtask

    task automatic wait_results(input int n);
        for (int i = 0; i < 40 && q_id.size() < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({busy_a, done_a, rvld_a, rdy_a, dvld_a} !== 8'h0) $display("FAIL reset_outputs: got %b want 0", {busy_a, done_a, rvld_a, rdy_a, dvld_a}); else passes++;
        done_cnt = 0;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checks++; if (done_cnt !== 1) $display("FAIL reset_init_pulse: got %0d want 1", done_cnt); else passes++;
        checks++; if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_a); else passes++;
        checks++; if (rdy_a !== 4'h0) $display("FAIL reset_rdy: got %h want 0", rdy_a); else passes++;
    endtask

    task automatic test_round_robin();
        int left[4] = '{2, 1, 1, 1};
        logic [1:0] exp_id[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        q_id.delete(); q_crc.delete(); q_len.delete();
        data_a = {4{8'h80}}; last_a = 4'hF; vld_a = 4'hF;
        for (int c = 0; c < 100 && vld_a != 4'h0; c++) begin
            @(negedge clk);
            for (int l = 0; l < 4; l++) if (rdy_a[l]) left[l]--;
            @(posedge clk); #1;
            for (int l = 0; l < 4; l++) if (left[l] == 0) vld_a[l] = 1'b0;
        end
        checks++; if (vld_a !== 4'h0) $display("FAIL rr_accepts: pending %b want 0000", vld_a); else passes++;
        wait_results(5);
        checks++; if (q_id.size() !== 5) $display("FAIL rr_count: got %0d want 5", q_id.size()); else passes++;
        for (int i = 0; i < 5 && i < q_id.size(); i++) begin
            checks++; if (q_id[i] !== exp_id[i]) $display("FAIL rr_id[%0d]: got %0d want %0d", i, q_id[i], exp_id[i]); else passes++;
            checks++; if (q_crc[i] !== 8'h89) $display("FAIL rr_crc[%0d]: got %h want 89", i, q_crc[i]); else passes++;
            checks++; if (q_len[i] !== 12'd1) $display("FAIL rr_len[%0d]: got %0d want 1", i, q_len[i]); else passes++;
        end
        checks++; if (overlap_cnt !== 0) $display("FAIL done_with_din: got %0d want 0", overlap_cnt); else passes++;
        checks++; if (res_twice !== 0) $display("FAIL res_vld_twice: got %0d want 0", res_twice); else passes++;
        last_a = 4'h0;
    endtask

    task automatic test_single();
        bit ok;
        q_id.delete(); q_crc.delete(); q_len.delete();
        send_byte(1'b0, 0, 8'h01, 1'b1, ok);
        checks++; if (ok !== 1'b1) $display("FAIL single_accept: got %b want 1", ok); else passes++;
        checks++; if ({done_a, dvld_a} !== 2'b10) $display("FAIL single_rslt_done: got %b want 10", {done_a, dvld_a}); else passes++;
        @(posedge clk); #1;
        checks++; if (rvld_a !== 1'b1) $display("FAIL single_res_vld: got %b want 1", rvld_a); else passes++;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (q_id.size() !== 1) $display("FAIL single_count: got %0d want 1", q_id.size()); else passes++;
        checks++; if ({rcrc_a, rid_a, rlen_a} !== {8'h07, 2'd0, 12'd1}) $display("FAIL single_result: got crc %h id %0d len %0d want 07 0 1", rcrc_a, rid_a, rlen_a); else passes++;
    endtask

    task automatic test_gap();
        bit ok;
        q_id.delete(); q_crc.delete(); q_len.delete();
        send_byte(1'b0, 2, 8'h01, 1'b0, ok);
        checks++; if (ok !== 1'b1) $display("FAIL gap_first: got %b want 1", ok); else passes++;
        vld_a[0] = 1'b1; last_a[0] = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            checks++; if ({busy_a, rdy_a, dvld_a} !== 6'b100000) $display("FAIL gap_hold: got %b want 100000", {busy_a, rdy_a, dvld_a}); else passes++;
        end
        vld_a[0] = 1'b0; last_a[0] = 1'b0;
        send_byte(1'b0, 2, 8'h00, 1'b1, ok);
        wait_results(1);
        checks++; if (q_id.size() !== 1) $display("FAIL gap_count: got %0d want 1", q_id.size()); else passes++;
        checks++; if ({rcrc_a, rid_a, rlen_a} !== {8'h15, 2'd2, 12'd2}) $display("FAIL gap_result: got crc %h id %0d len %0d want 15 2 2", rcrc_a, rid_a, rlen_a); else passes++;
        last_a = 4'h0;
    endtask

    task automatic test_mid_reset();
        bit ok;
        int n;
        q_id.delete(); q_crc.delete(); q_len.delete();
        send_byte(1'b0, 1, 8'h55, 1'b0, ok);
        data_a[15:8] = 8'hAA; vld_a[1] = 1'b1;
        #1;
        checks++; if (rdy_a !== 4'b0010) $display("FAIL midrst_pre_rdy: got %b want 0010", rdy_a); else passes++;
        rst_n = 1'b0;
        #1;
        checks++; if ({rdy_a, busy_a, rvld_a, done_a, dvld_a} !== 8'h0) $display("FAIL midrst_async: got %b want 0", {rdy_a, busy_a, rvld_a, done_a, dvld_a}); else passes++;
        repeat (2) @(posedge clk);
        vld_a = 4'h0;
        #1 done_cnt = 0;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checks++; if (done_cnt !== 1) $display("FAIL midrst_init_pulse: got %0d want 1", done_cnt); else passes++;
        n = q_id.size();
        checks++; if (n !== 0) $display("FAIL midrst_no_result: got %0d want 0", n); else passes++;
        send_byte(1'b0, 0, 8'h01, 1'b1, ok);
        wait_results(1);
        checks++; if ({rcrc_a, rid_a, rlen_a} !== {8'h07, 2'd0, 12'd1}) $display("FAIL midrst_new_frame: got crc %h id %0d len %0d want 07 0 1", rcrc_a, rid_a, rlen_a); else passes++;
    endtask

    task automatic test_saturate();
        bit ok, seen;
        logic [7:0] exp_crc = 8'h00, d;
        int acc = 0;
        for (int i = 0; i < 20; i++) begin
            d = 8'(i * 7 + 3);
            exp_crc = crc_step(exp_crc, d);
            send_byte(1'b1, 2, d, i == 19, ok);
            if (ok) acc++;
        end
        checks++; if (acc !== 20) $display("FAIL sat_accepts: got %0d want 20", acc); else passes++;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (rvld_b) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        checks++; if (seen !== 1'b1) $display("FAIL sat_res_vld: got %b want 1", seen); else passes++;
        checks++; if (rlen_b !== 4'd15) $display("FAIL sat_len: got %0d want 15", rlen_b); else passes++;
        checks++; if (rcrc_b !== exp_crc) $display("FAIL sat_crc: got %h want %h", rcrc_b, exp_crc); else passes++;
        checks++; if (rid_b !== 2'd2) $display("FAIL sat_id: got %0d want 2", rid_b); else passes++;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_gap();
        test_mid_reset();
        test_saturate();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
